axis_pr_freeze_ctrl: RTL and testbench

AXIS_PR_FREEZE_CTRL -- requirements
Module: axis_pr_freeze_ctrl

---
 rtl/pr_frz_ctrl_pkg.sv | 27 ++
 rtl/axis_pkt_boundary_trk.sv | 32 +++
 rtl/axis_pr_freeze_ctrl.sv | 162 ++++++++++++++++
 tb/tb_axis_pr_freeze_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pr_frz_ctrl_pkg.sv
// Shared types and default timing for the partial-reconfiguration freeze controller.
// Holds the FSM state encoding, reset-time constants and a counter-width helper.
package pr_frz_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_DRAIN     = 3'd1,
        ST_FROZEN    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RELEASE   = 3'd4
    } state_e;

    localparam int DEF_DRAIN_TIMEOUT = 4096;
    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_SETTLE_CYCLES = 8;
    localparam int DEF_CNT_W         = 16;

    // Bits needed to count 0 .. max(a,b,c)-1.
    function automatic int cnt_w_needed(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/axis_pkt_boundary_trk.sv
// Tracks whether one AXI-Stream direction is between the first and last beat of a packet.
// in_pkt_nxt folds in the current cycle's handshake so the caller can act on it this cycle.
module axis_pkt_boundary_trk (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tvalid,
    input  logic tready,
    input  logic tlast,
    output logic in_pkt_nxt
);

    logic in_pkt_q;
    logic in_pkt_d;

    always_comb begin
        in_pkt_nxt = in_pkt_q;
        if (tvalid && tready) begin
            in_pkt_nxt = !tlast;
        end
        in_pkt_d = clr ? 1'b0 : in_pkt_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_pkt_q <= 1'b0;
        end else begin
            in_pkt_q <= in_pkt_d;
        end
    end

endmodule

// File: rtl/axis_pr_freeze_ctrl.sv
// Freeze/reset sequencer for a reconfigurable AXI-Stream port: drains to a packet
// boundary (or times out), freezes, holds port reset, then releases on PR done.
module axis_pr_freeze_ctrl
    import pr_frz_ctrl_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pr_req,
    input  logic       tx_tvalid,
    input  logic       tx_tready,
    input  logic       tx_tlast,
    input  logic       rx_tvalid,
    input  logic       rx_tready,
    input  logic       rx_tlast,
    output logic       pr_freeze,
    output logic       port_rst_n,
    output logic       freeze_ack,
    output logic       timeout_err,
    output logic [2:0] state
);

    if (DRAIN_TIMEOUT < 1 || RST_CYCLES < 1 || SETTLE_CYCLES < 1 ||
        CNT_W < cnt_w_needed(DRAIN_TIMEOUT, RST_CYCLES, SETTLE_CYCLES)) begin : g_param_chk
        $error("axis_pr_freeze_ctrl: CNT_W too narrow or a cycle count below 1");
    end

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pr_freeze_q, pr_freeze_d;
    logic             port_rst_n_q, port_rst_n_d;
    logic             freeze_ack_q, freeze_ack_d;
    logic             timeout_err_q, timeout_err_d;
    logic             force_clr;
    logic             trk_clr;
    logic             tx_in_pkt_nxt;
    logic             rx_in_pkt_nxt;

    // Trackers are flushed while frozen and on a forced (timeout) freeze.
    assign trk_clr = pr_freeze_q | force_clr;

    axis_pkt_boundary_trk u_tx_trk (
        .clk        (clk),
        .rst        (rst),
        .clr        (trk_clr),
        .tvalid     (tx_tvalid),
        .tready     (tx_tready),
        .tlast      (tx_tlast),
        .in_pkt_nxt (tx_in_pkt_nxt)
    );

    axis_pkt_boundary_trk u_rx_trk (
        .clk        (clk),
        .rst        (rst),
        .clr        (trk_clr),
        .tvalid     (rx_tvalid),
        .tready     (rx_tready),
        .tlast      (rx_tlast),
        .in_pkt_nxt (rx_in_pkt_nxt)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        pr_freeze_d   = pr_freeze_q;
        port_rst_n_d  = port_rst_n_q;
        freeze_ack_d  = freeze_ack_q;
        timeout_err_d = timeout_err_q;
        force_clr     = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                pr_freeze_d  = 1'b0;
                port_rst_n_d = 1'b1;
                freeze_ack_d = 1'b0;
                cnt_d        = '0;
                if (pr_req) begin
                    state_d       = ST_DRAIN;
                    timeout_err_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (!pr_req) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (!tx_in_pkt_nxt && !rx_in_pkt_nxt) begin
                    // Freeze lands on the edge right after the last beat, so no new packet can start.
                    state_d      = ST_FROZEN;
                    pr_freeze_d  = 1'b1;
                    port_rst_n_d = 1'b0;
                    cnt_d        = '0;
                end else if (cnt_q >= DRAIN_LAST) begin
                    state_d       = ST_FROZEN;
                    pr_freeze_d   = 1'b1;
                    port_rst_n_d  = 1'b0;
                    timeout_err_d = 1'b1;
                    force_clr     = 1'b1;
                    cnt_d         = '0;
                end
            end
            ST_FROZEN: begin
                if (cnt_q >= RST_LAST) begin
                    state_d      = ST_WAIT_DONE;
                    freeze_ack_d = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!pr_req) begin
                    state_d      = ST_RELEASE;
                    port_rst_n_d = 1'b1;
                    freeze_ack_d = 1'b0;
                    cnt_d        = '0;
                end
            end
            ST_RELEASE: begin
                if (cnt_q >= SETTLE_LAST) begin
                    state_d     = ST_RUN;
                    pr_freeze_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            pr_freeze_q   <= 1'b0;
            port_rst_n_q  <= 1'b0;
            freeze_ack_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pr_freeze_q   <= pr_freeze_d;
            port_rst_n_q  <= port_rst_n_d;
            freeze_ack_q  <= freeze_ack_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign pr_freeze   = pr_freeze_q;
    assign port_rst_n  = port_rst_n_q;
    assign freeze_ack  = freeze_ack_q;
    assign timeout_err = timeout_err_q;
    assign state       = state_q;

endmodule

// File: tb/tb_axis_pr_freeze_ctrl.sv
// Bench for axis_pr_freeze_ctrl: directed scenarios plus random traffic, every cycle
// compared against a countdown-based reference model of the freeze sequence.
module tb_axis_pr_freeze_ctrl;
    import pr_frz_ctrl_pkg::*;

    localparam int DT = 64;
    localparam int RC = 16;
    localparam int SC = 8;

    logic       clk;
    logic       rst;
    logic       pr_req;
    logic       tx_tvalid, tx_tready, tx_tlast;
    logic       rx_tvalid, rx_tready, rx_tlast;
    logic       pr_freeze, port_rst_n, freeze_ack, timeout_err;
    logic [2:0] state;

    int n_chk = 0;
    int n_bad = 0;

    // reference model
    state_e m_ph;
    int     m_left;
    bit     m_frz, m_prn, m_ack, m_err, m_tx, m_rx;

    axis_pr_freeze_ctrl #(
        .DRAIN_TIMEOUT (DT),
        .RST_CYCLES    (RC),
        .SETTLE_CYCLES (SC),
        .CNT_W         (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pr_req      (pr_req),
        .tx_tvalid   (tx_tvalid),
        .tx_tready   (tx_tready),
        .tx_tlast    (tx_tlast),
        .rx_tvalid   (rx_tvalid),
        .rx_tready   (rx_tready),
        .rx_tlast    (rx_tlast),
        .pr_freeze   (pr_freeze),
        .port_rst_n  (port_rst_n),
        .freeze_ack  (freeze_ack),
        .timeout_err (timeout_err),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of the sequence rules, using countdowns of remaining cycles per phase.
    task automatic model_step();
        bit tx_after, rx_after, frz_now, clr_now;
        tx_after = (tx_tvalid && tx_tready) ? !tx_tlast : m_tx;
        rx_after = (rx_tvalid && rx_tready) ? !rx_tlast : m_rx;
        frz_now  = m_frz;
        clr_now  = 1'b0;
        if (rst) begin
            m_ph = ST_RUN; m_left = 0;
            m_frz = 0; m_prn = 0; m_ack = 0; m_err = 0; m_tx = 0; m_rx = 0;
        end else begin
            case (m_ph)
                ST_RUN: begin
                    m_prn = 1;
                    if (pr_req) begin m_ph = ST_DRAIN; m_left = DT; m_err = 0; end
                end
                ST_DRAIN: begin
                    if (!pr_req) m_ph = ST_RUN;
                    else if (!tx_after && !rx_after) begin
                        m_ph = ST_FROZEN; m_frz = 1; m_prn = 0; m_left = RC;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_ph = ST_FROZEN; m_frz = 1; m_prn = 0; m_err = 1;
                            clr_now = 1; m_left = RC;
                        end
                    end
                end
                ST_FROZEN: begin
                    m_left--;
                    if (m_left == 0) begin m_ph = ST_WAIT_DONE; m_ack = 1; end
                end
                ST_WAIT_DONE: begin
                    if (!pr_req) begin m_ph = ST_RELEASE; m_prn = 1; m_ack = 0; m_left = SC; end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin m_ph = ST_RUN; m_frz = 0; end
                end
            endcase
            m_tx = (frz_now || clr_now) ? 1'b0 : tx_after;
            m_rx = (frz_now || clr_now) ? 1'b0 : rx_after;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("m_state", 32'(state), 32'(m_ph));
        chk("m_pr_freeze", 32'(pr_freeze), 32'(m_frz));
        chk("m_port_rst_n", 32'(port_rst_n), 32'(m_prn));
        chk("m_freeze_ack", 32'(freeze_ack), 32'(m_ack));
        chk("m_timeout_err", 32'(timeout_err), 32'(m_err));
    endtask

    task automatic idle_streams();
        tx_tvalid = 0; tx_tready = 0; tx_tlast = 0;
        rx_tvalid = 0; rx_tready = 0; rx_tlast = 0;
    endtask

    task automatic tx_beat(input bit last);
        tx_tvalid = 1; tx_tready = 1; tx_tlast = last;
    endtask

    initial begin
        bit stall;
        rst = 1; pr_req = 0;
        idle_streams();
        m_ph = ST_RUN; m_left = 0;
        m_frz = 0; m_prn = 0; m_ack = 0; m_err = 0; m_tx = 0; m_rx = 0;

        // reset values
        repeat (3) tick();
        chk("rst_freeze", 32'(pr_freeze), 0);
        chk("rst_port_rst_n", 32'(port_rst_n), 0);
        chk("rst_ack", 32'(freeze_ack), 0);
        chk("rst_state", 32'(state), 32'(ST_RUN));
        rst = 0;
        tick();
        chk("prn_rise_after_rst", 32'(port_rst_n), 1);
        repeat (5) tick();

        // idle freeze timing, then release
        pr_req = 1;
        tick();
        chk("idle_drain", 32'(state), 32'(ST_DRAIN));
        tick();
        chk("idle_freeze", 32'(pr_freeze), 1);
        chk("idle_prn_low", 32'(port_rst_n), 0);
        repeat (RC - 1) tick();
        chk("idle_ack_not_yet", 32'(freeze_ack), 0);
        tick();
        chk("idle_ack", 32'(freeze_ack), 1);
        chk("idle_wait_done", 32'(state), 32'(ST_WAIT_DONE));
        repeat (4) tick();
        pr_req = 0;
        tick();
        chk("rel_prn_high", 32'(port_rst_n), 1);
        chk("rel_ack_low", 32'(freeze_ack), 0);
        repeat (SC - 1) tick();
        chk("rel_freeze_held", 32'(pr_freeze), 1);
        tick();
        chk("rel_freeze_drop", 32'(pr_freeze), 0);
        chk("rel_run", 32'(state), 32'(ST_RUN));

        // TX packet in flight: freeze one cycle after tlast
        tx_beat(0); tick();
        tx_beat(0); tick();
        idle_streams(); pr_req = 1; tick();
        tx_beat(0); tick();
        chk("pkt_no_freeze_mid", 32'(pr_freeze), 0);
        tx_beat(1); tick();
        chk("pkt_freeze_after_last", 32'(pr_freeze), 1);
        tx_tvalid = 1; tx_tready = 0; tx_tlast = 0;
        repeat (RC) tick();
        idle_streams(); pr_req = 0;
        repeat (SC + 1) tick();
        chk("pkt_back_run", 32'(state), 32'(ST_RUN));

        // stuck mid-packet: forced freeze after DT drain cycles
        tx_beat(0); tick();
        tx_tvalid = 1; tx_tready = 0; pr_req = 1; tick();
        repeat (DT - 1) tick();
        chk("to_not_yet", 32'(pr_freeze), 0);
        tick();
        chk("to_freeze", 32'(pr_freeze), 1);
        chk("to_err", 32'(timeout_err), 1);
        chk("to_frozen", 32'(state), 32'(ST_FROZEN));
        idle_streams();
        repeat (RC) tick();
        pr_req = 0;
        repeat (SC + 1) tick();
        chk("to_err_sticky", 32'(timeout_err), 1);

        // rst in FROZEN aborts to RUN
        pr_req = 1; tick(); tick(); repeat (3) tick();
        rst = 1; tick();
        chk("abort_state", 32'(state), 32'(ST_RUN));
        chk("abort_freeze", 32'(pr_freeze), 0);
        chk("abort_prn", 32'(port_rst_n), 0);
        chk("abort_ack", 32'(freeze_ack), 0);
        chk("abort_err", 32'(timeout_err), 0);
        rst = 0; pr_req = 0; tick();
        chk("abort_prn_rise", 32'(port_rst_n), 1);

        // pr_req pulse in DRAIN before boundary
        tx_beat(0); tick();
        idle_streams(); pr_req = 1; tick();
        pr_req = 0; tick();
        chk("pulse_run", 32'(state), 32'(ST_RUN));
        repeat (4) tick();
        chk("pulse_no_freeze", 32'(pr_freeze), 0);
        tx_beat(1); tick();
        idle_streams(); tick();

        // random traffic with the bridge gating tready by pr_freeze
        stall = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) pr_req = ~pr_req;
            if ($urandom_range(0, 29) == 0) stall = ~stall;
            rst       = ($urandom_range(0, 599) == 0);
            tx_tvalid = $urandom_range(0, 1);
            tx_tlast  = ($urandom_range(0, 3) == 0);
            tx_tready = ($urandom_range(0, 9) < 7) && !stall && !pr_freeze;
            rx_tvalid = $urandom_range(0, 1);
            rx_tlast  = ($urandom_range(0, 3) == 0);
            rx_tready = ($urandom_range(0, 9) < 7) && !pr_freeze;
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
